sockit_spi_csr: RTL and testbench
=================================

# sockit_spi_csr

Memory-mapped configuration, control, status and interrupt register block for the SPI master. It sits between the CPU bus and the SPI command/response streams, in the same position as the single-entry register block it supersedes. It adds parametrised command-output and response-input FIFOs, a populated parameterization register, FIFO fill-level status, and a maskable, sticky interrupt controller. The CPU can queue several SPI commands and collect several responses without polling per transfer.

## Interface
- CFG_RST, 32'h00000000, spi_cfg reset value
- CFG_MSK, 32'hffffffff, spi_cfg writable-bit mask (1 = writable)
- ADR_ROF, 32'h00000000, adr_rof reset value
- ADR_WOF, 32'h00000000, adr_wof reset value
- CCO, 12, command control output width
- CCI, 4, command control input width (legal 1..4)
- CDW, 32, command data width (legal 1..32)
- FOD, 4, command-output FIFO depth (power of 2, 2..128)
- FID, 4, response-input FIFO depth (power of 2, 2..128)
- SSN, 8, number of slave selects (1..8)
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- reg_wen / reg_ren  in  1  bus write / read enable
- reg_adr  in  3  register address
- reg_wdt  in  32  write data
- reg_rdt  out  32  read data (combinational from reg_adr)
- reg_wrq  out  1  wait request
- reg_err  out  1  error response
- reg_irq  out  1  interrupt request
- spi_cfg, adr_rof, adr_wof  out  32  configuration and XIP/DMA address offsets
- cmo_vld out 1 / cmo_ctl out CCO / cmo_dat out CDW / cmo_rdy in 1  command output stream
- cmi_vld in 1 / cmi_ctl in CCI / cmi_dat in CDW / cmi_rdy out 1  response input stream
- tsk_vld out 1 / tsk_ctl out 32 / tsk_sts in 32 / tsk_rdy in 1  DMA task interface

## Operation
Address map:
- 0x0 spi_cfg: R/W. Write stores CFG_RST&~CFG_MSK | reg_wdt&CFG_MSK.
- 0x1 spi_par: read-only; writes are ignored with no error. Fields: [3:0] log2(FOD), [7:4] log2(FID), [10:8] SSN-1, all others 0.
- 0x2 spi_ctl/sts: write pushes {reg_wdt[12:8], reg_wdt[6:0]} (CCO bits) together with the staged data word into the command FIFO.
- 0x2 read fields: [0] cmo empty, [1] cmo full, [2] cmi empty, [3] cmi full, [11:8] cmi_ctl of the cmi head entry (zero-extended; 0 if empty), [23:16] cmo count, [31:24] cmi count.
- 0x3 spi_dat: write loads the staging data register and does not push. Read returns the cmi head data zero-extended and pops it.
- 0x3 read of an empty cmi FIFO: reg_err=1 for that cycle, reg_rdt=0, no pop, and irq source 3 is set.
- 0x4 spi_irq: [3:0] pending bits, write-1-to-clear. [11:8] enable bits, plain R/W.
- 0x5 dma: a write with tsk_rdy=1 asserts tsk_vld=1 with tsk_ctl=reg_wdt. A read returns tsk_sts.
- 0x6 adr_rof, 0x7 adr_wof: R/W.

FIFOs:
- cmo_vld = ~cmo_empty; cmo_ctl/cmo_dat show the head entry.
- A pop occurs on cmo_vld&cmo_rdy.
- cmi_rdy = ~cmi_full. A push occurs on cmi_vld&cmi_rdy, storing {cmi_ctl, cmi_dat}.
- Both FIFOs use pointers one bit wider than log2(depth), and wrap modulo 2*depth. Count = wptr-rptr, range 0..depth.

Interrupt sources (each sets its pending bit for one event):
- 0: cmo FIFO transitions non-empty to empty.
- 1: cmi push.
- 2: tsk_rdy rising edge.
- 3: read of an empty cmi FIFO.

reg_irq = |(pending & enable).

Wait request:
- Write to 0x2 while cmo full: reg_wrq=1.
- Any access to 0x5 while tsk_rdy=0: reg_wrq=1.
- All other cases: reg_wrq=0. No side effect occurs while reg_wrq=1.

## Timing
- Reset values: spi_cfg=CFG_RST, adr_rof=ADR_ROF, adr_wof=ADR_WOF.
- Reset values: both FIFOs empty, so cmo_vld=0 and cmi_rdy=1.
- Reset values: pending=0, enable=0, reg_irq=0, staging register=0, tsk_vld=0.
- cmo_ctl/cmo_dat are don't-care while cmo_vld=0.
- FIFO memories are not reset.
- A reset mid-operation discards all FIFO contents in the cycle it is sampled.
- Bus write to 0x2 at edge N: cmo_vld=1 from cycle N+1.
- cmi push at edge N: entry readable, and pending[1] set, from cycle N+1. reg_irq is visible in the same cycle as pending.
- Simultaneous push and pop on the same FIFO: count is unchanged. A full cmo still stalls the bus that cycle, because reg_wrq depends only on full.
- An irq set event and a W1C on the same bit in the same cycle: set wins.
- Staging register persists after a push, so repeated ctl writes reuse the same data.
- tsk_vld is combinational and lasts one cycle per accepted write.

## Test plan
- Reset, then read 0x1 with FOD=4, FID=8, SSN=8 -> 0x00000732. Read 0x2 -> 0x00000005.
- Write 0x3=0xA5A5A5A5, then write 0x2 four times with cmo_rdy=0 -> all four accepted. A fifth write stalls with reg_wrq=1 until cmo_rdy pulses. Entries emerge in order with cmo_dat=0xA5A5A5A5.
- Push 4 cmi entries (data 1..4) with FID=4 -> cmi_rdy=0 after the 4th. Reads of 0x3 return 1,2,3,4. A fifth read gives reg_err=1, reg_rdt=0.
- Enable irq bit 0, drain the cmo FIFO -> pending[0]=1 and reg_irq=1 the next cycle. Write 0x4=0x1 -> reg_irq=0.
- W1C of bit 1 coincident with a cmi push -> pending[1] remains 1.
- Write 0x5 with tsk_rdy=0 -> reg_wrq=1 and tsk_vld=0. Raise tsk_rdy -> tsk_vld=1 for one cycle with tsk_ctl=reg_wdt, and pending[2] is set.

Source files
------------

// File: rtl/sockit_spi_csr.sv
// SPI master register block: bus-facing CSRs, command/response FIFOs,
// sticky maskable interrupts and a DMA task handshake.

// Synchronous FIFO with extra-MSB pointers so full and empty are distinct.
module sockit_spi_fifo #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] wdt,
   input  logic          pop,
   output logic [DW-1:0] rdt,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   cnt
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;

   // Pointer update; callers guarantee push only when not full, pop only when not empty.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage write port.
   // NOTE: the array has no reset; emptiness is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= wdt;
   end

   assign rdt   = mem[rptr[AW-1:0]];
   assign cnt   = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

module sockit_spi_csr #(
   parameter logic [31:0] CFG_RST = 32'h0000_0000,
   parameter logic [31:0] CFG_MSK = 32'hffff_ffff,
   parameter logic [31:0] ADR_ROF = 32'h0000_0000,
   parameter logic [31:0] ADR_WOF = 32'h0000_0000,
   parameter int unsigned CCO     = 12,
   parameter int unsigned CCI     = 4,
   parameter int unsigned CDW     = 32,
   parameter int unsigned FOD     = 4,
   parameter int unsigned FID     = 4,
   parameter int unsigned SSN     = 8
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           reg_wen,
   input  logic           reg_ren,
   input  logic [2:0]     reg_adr,
   input  logic [31:0]    reg_wdt,
   output logic [31:0]    reg_rdt,
   output logic           reg_wrq,
   output logic           reg_err,
   output logic           reg_irq,
   output logic [31:0]    spi_cfg,
   output logic [31:0]    adr_rof,
   output logic [31:0]    adr_wof,
   output logic           cmo_vld,
   output logic [CCO-1:0] cmo_ctl,
   output logic [CDW-1:0] cmo_dat,
   input  logic           cmo_rdy,
   input  logic           cmi_vld,
   input  logic [CCI-1:0] cmi_ctl,
   input  logic [CDW-1:0] cmi_dat,
   output logic           cmi_rdy,
   output logic           tsk_vld,
   output logic [31:0]    tsk_ctl,
   input  logic [31:0]    tsk_sts,
   input  logic           tsk_rdy
);

   localparam int unsigned OAW = $clog2(FOD);
   localparam int unsigned IAW = $clog2(FID);

   typedef enum logic [2:0] {
      ADR_CFG = 3'd0,
      ADR_PAR = 3'd1,
      ADR_CTL = 3'd2,
      ADR_DAT = 3'd3,
      ADR_IRQ = 3'd4,
      ADR_DMA = 3'd5,
      ADR_RFO = 3'd6,
      ADR_WFO = 3'd7
   } reg_adr_t;

   reg_adr_t adr;
   assign adr = reg_adr_t'(reg_adr);

   // Registers
   logic [CDW-1:0] dat_stg;
   logic [3:0]     irq_pnd;
   logic [3:0]     irq_ena;
   logic           tsk_rdy_q;

   // FIFO plumbing
   logic           cmo_push, cmo_pop, cmo_empty, cmo_full;
   logic [OAW:0]   cmo_cnt;
   logic           cmi_push, cmi_pop, cmi_empty, cmi_full;
   logic [IAW:0]   cmi_cnt;
   logic [CCI-1:0] cmi_hctl;
   logic [CDW-1:0] cmi_hdat;

   logic           wr_en, rd_en, rd_dat;
   logic [3:0]     irq_set, irq_clr;
   logic [31:0]    par_val;
   logic [3:0]     sts_ctl;
   logic [31:0]    sts_dat;
   logic [7:0]     sts_ocnt, sts_icnt;

   // Wait request: only a full command FIFO or an unready DMA engine stalls the bus.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      reg_wrq = 1'b0;
      if (reg_wen && (adr == ADR_CTL) && cmo_full) reg_wrq = 1'b1;
      if ((reg_wen || reg_ren) && (adr == ADR_DMA) && !tsk_rdy) reg_wrq = 1'b1;
   end

   assign wr_en    = reg_wen & ~reg_wrq;
   assign rd_en    = reg_ren & ~reg_wrq;
   assign rd_dat   = rd_en & (adr == ADR_DAT);

   assign cmo_push = wr_en & (adr == ADR_CTL);
   assign cmo_pop  = cmo_vld & cmo_rdy;
   assign cmo_vld  = ~cmo_empty;

   assign cmi_rdy  = ~cmi_full;
   assign cmi_push = cmi_vld & cmi_rdy;
   assign cmi_pop  = rd_dat & ~cmi_empty;
   assign reg_err  = rd_dat & cmi_empty;

   assign tsk_vld  = wr_en & (adr == ADR_DMA);
   assign tsk_ctl  = reg_wdt;

   sockit_spi_fifo #(.DW(CCO+CDW), .DEPTH(FOD)) u_cmo (
      .clk   (clk),
      .rst   (rst),
      .push  (cmo_push),
      .wdt   ({CCO'({reg_wdt[12:8], reg_wdt[6:0]}), dat_stg}),
      .pop   (cmo_pop),
      .rdt   ({cmo_ctl, cmo_dat}),
      .empty (cmo_empty),
      .full  (cmo_full),
      .cnt   (cmo_cnt)
   );

   sockit_spi_fifo #(.DW(CCI+CDW), .DEPTH(FID)) u_cmi (
      .clk   (clk),
      .rst   (rst),
      .push  (cmi_push),
      .wdt   ({cmi_ctl, cmi_dat}),
      .pop   (cmi_pop),
      .rdt   ({cmi_hctl, cmi_hdat}),
      .empty (cmi_empty),
      .full  (cmi_full),
      .cnt   (cmi_cnt)
   );

   // Source 0 fires on the pop that leaves the command FIFO empty, so pending
   // rises in the same cycle cmo_vld falls.
   assign irq_set = {reg_err,
                     tsk_rdy & ~tsk_rdy_q,
                     cmi_push,
                     cmo_pop & ~cmo_push & (cmo_cnt == (OAW+1)'(1))};
   assign irq_clr = (wr_en && (adr == ADR_IRQ)) ? reg_wdt[3:0] : 4'b0000;
   assign reg_irq = |(irq_pnd & irq_ena);

   // CSR writes and sticky interrupt pending; a set event beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         spi_cfg   <= CFG_RST;
         adr_rof   <= ADR_ROF;
         adr_wof   <= ADR_WOF;
         dat_stg   <= '0;
         irq_pnd   <= '0;
         irq_ena   <= '0;
         tsk_rdy_q <= 1'b0;
      end else begin
         if (wr_en) begin
            case (adr)
               ADR_CFG: spi_cfg <= (CFG_RST & ~CFG_MSK) | (reg_wdt & CFG_MSK);
               ADR_DAT: dat_stg <= reg_wdt[CDW-1:0];
               ADR_IRQ: irq_ena <= reg_wdt[11:8];
               ADR_RFO: adr_rof <= reg_wdt;
               ADR_WFO: adr_wof <= reg_wdt;
               default: ;
            endcase
         end
         irq_pnd   <= (irq_pnd & ~irq_clr) | irq_set;
         tsk_rdy_q <= tsk_rdy;
      end
   end

   assign par_val = {21'd0, 3'(SSN-1), 4'(IAW), 4'(OAW)};

   // Zero-extend response head and fill levels into fixed-width status fields.
   always_comb begin
      sts_ctl  = '0;
      sts_dat  = '0;
      sts_ocnt = '0;
      sts_icnt = '0;
      if (!cmi_empty) begin
         sts_ctl[CCI-1:0] = cmi_hctl;
         sts_dat[CDW-1:0] = cmi_hdat;
      end
      sts_ocnt[OAW:0] = cmo_cnt;
      sts_icnt[IAW:0] = cmi_cnt;
   end

   // Read mux, combinational from the address.
   always_comb begin
      reg_rdt = '0;
      case (adr)
         ADR_CFG: reg_rdt = spi_cfg;
         ADR_PAR: reg_rdt = par_val;
         ADR_CTL: reg_rdt = {sts_icnt, sts_ocnt, 4'b0000, sts_ctl, 4'b0000,
                             cmi_full, cmi_empty, cmo_full, cmo_empty};
         ADR_DAT: reg_rdt = sts_dat;
         ADR_IRQ: reg_rdt = {20'd0, irq_ena, 4'b0000, irq_pnd};
         ADR_DMA: reg_rdt = tsk_sts;
         ADR_RFO: reg_rdt = adr_rof;
         ADR_WFO: reg_rdt = adr_wof;
      endcase
   end

endmodule

// File: tb/tb_sockit_spi_csr.sv
// Self-checking bench for sockit_spi_csr: scoreboard for bus reads and
// command-stream output, directed checks for handshake and interrupt signals.
module tb_sockit_spi_csr;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_wen, reg_ren;
   logic [2:0]  reg_adr;
   logic [31:0] reg_wdt, reg_rdt;
   logic        reg_wrq, reg_err, reg_irq;
   logic [31:0] spi_cfg, adr_rof, adr_wof;
   logic        cmo_vld, cmo_rdy;
   logic [11:0] cmo_ctl;
   logic [31:0] cmo_dat;
   logic        cmi_vld, cmi_rdy;
   logic [3:0]  cmi_ctl;
   logic [31:0] cmi_dat;
   logic        tsk_vld, tsk_rdy;
   logic [31:0] tsk_ctl, tsk_sts;

   // second instance only to observe the parameterization register
   logic [31:0] p_rdt, p_cfg, p_rof, p_wof, p_cdat, p_tctl;
   logic [11:0] p_cctl;
   logic        p_wrq, p_err, p_irq, p_cvld, p_crdy, p_tvld;

   localparam logic [31:0] CFG_RST = 32'h1234_0000;
   localparam logic [31:0] CFG_MSK = 32'h0000_ffff;
   localparam logic [31:0] STG     = 32'ha5a5_a5a5;

   int n_checks = 0;
   int n_errors = 0;

   logic [32:0] rd_exp_q [$];
   string       rd_name_q [$];
   logic [43:0] cmo_exp_q [$];

   always #5 clk = ~clk;

   sockit_spi_csr #(
      .CFG_RST(CFG_RST), .CFG_MSK(CFG_MSK), .ADR_ROF(32'h0000_1000), .ADR_WOF(32'h0000_2000),
      .CCO(12), .CCI(4), .CDW(32), .FOD(4), .FID(4), .SSN(8)
   ) dut (
      .clk(clk), .rst(rst), .reg_wen(reg_wen), .reg_ren(reg_ren), .reg_adr(reg_adr),
      .reg_wdt(reg_wdt), .reg_rdt(reg_rdt), .reg_wrq(reg_wrq), .reg_err(reg_err),
      .reg_irq(reg_irq), .spi_cfg(spi_cfg), .adr_rof(adr_rof), .adr_wof(adr_wof),
      .cmo_vld(cmo_vld), .cmo_ctl(cmo_ctl), .cmo_dat(cmo_dat), .cmo_rdy(cmo_rdy),
      .cmi_vld(cmi_vld), .cmi_ctl(cmi_ctl), .cmi_dat(cmi_dat), .cmi_rdy(cmi_rdy),
      .tsk_vld(tsk_vld), .tsk_ctl(tsk_ctl), .tsk_sts(tsk_sts), .tsk_rdy(tsk_rdy)
   );

   sockit_spi_csr #(.FOD(4), .FID(8), .SSN(8)) u_par (
      .clk(clk), .rst(rst), .reg_wen(1'b0), .reg_ren(1'b0), .reg_adr(3'd1),
      .reg_wdt(32'd0), .reg_rdt(p_rdt), .reg_wrq(p_wrq), .reg_err(p_err),
      .reg_irq(p_irq), .spi_cfg(p_cfg), .adr_rof(p_rof), .adr_wof(p_wof),
      .cmo_vld(p_cvld), .cmo_ctl(p_cctl), .cmo_dat(p_cdat), .cmo_rdy(1'b0),
      .cmi_vld(1'b0), .cmi_ctl(4'd0), .cmi_dat(32'd0), .cmi_rdy(p_crdy),
      .tsk_vld(p_tvld), .tsk_ctl(p_tctl), .tsk_sts(32'd0), .tsk_rdy(1'b0)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compares every accepted bus read and every command-stream pop.
   always @(negedge clk) begin : monitor
      logic [32:0] e;
      logic [43:0] c;
      string       n;
      if (!rst && reg_ren && !reg_wrq) begin
         if (rd_exp_q.size() == 0) check("rd_unexpected", 1, 0);
         else begin
            e = rd_exp_q.pop_front();
            n = rd_name_q.pop_front();
            check(n, {31'd0, reg_err, reg_rdt}, {31'd0, e});
         end
      end
      if (!rst && cmo_vld && cmo_rdy) begin
         if (cmo_exp_q.size() == 0) check("cmo_unexpected", 1, 0);
         else begin
            c = cmo_exp_q.pop_front();
            check("cmo_entry", {20'd0, cmo_ctl, cmo_dat}, {20'd0, c});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] adr, input logic [31:0] dat);
      bit done = 1'b0;
      reg_wen = 1'b1; reg_adr = adr; reg_wdt = dat;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (!reg_wrq) done = 1'b1;
      end
      check("wr_accept", 64'(done), 1);
      step();
      reg_wen = 1'b0;
   endtask

   task automatic bus_read(input string name, input logic [2:0] adr,
                           input logic [31:0] exp_rdt, input logic exp_err);
      bit done = 1'b0;
      rd_exp_q.push_back({exp_err, exp_rdt});
      rd_name_q.push_back(name);
      reg_ren = 1'b1; reg_adr = adr;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (!reg_wrq) done = 1'b1;
      end
      check("rd_accept", 64'(done), 1);
      step();
      reg_ren = 1'b0;
   endtask

   task automatic cmi_send(input logic [3:0] ctl, input logic [31:0] dat);
      bit done = 1'b0;
      cmi_vld = 1'b1; cmi_ctl = ctl; cmi_dat = dat;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (cmi_rdy) done = 1'b1;
      end
      check("cmi_accept", 64'(done), 1);
      step();
      cmi_vld = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bit done;
      logic [11:0] ctl_v [5] = '{12'h001, 12'h080, 12'hfff, 12'h055, 12'h52a};
      logic [31:0] wdt_v [5] = '{32'h0000_0001, 32'h0000_0180, 32'h0000_1f7f,
                                 32'hffff_e055, 32'h0000_0a2a};

      rst = 1'b1; reg_wen = 0; reg_ren = 0; reg_adr = 0; reg_wdt = 0;
      cmo_rdy = 0; cmi_vld = 0; cmi_ctl = 0; cmi_dat = 0;
      tsk_rdy = 0; tsk_sts = 32'hcafe_f00d;
      repeat (2) step();
      rst = 1'b0;

      // reset state
      @(negedge clk);
      check("rst_spi_cfg", spi_cfg, CFG_RST);
      check("rst_adr_rof", adr_rof, 32'h0000_1000);
      check("rst_adr_wof", adr_wof, 32'h0000_2000);
      check("rst_cmo_vld", cmo_vld, 0);
      check("rst_cmi_rdy", cmi_rdy, 1);
      check("rst_irq", reg_irq, 0);
      check("rst_tsk_vld", tsk_vld, 0);
      check("par_fid8", p_rdt, 32'h0000_0732);
      step();
      bus_read("par_fid4", 3'd1, 32'h0000_0722, 0);
      bus_read("sts_reset", 3'd2, 32'h0000_0005, 0);
      bus_read("irq_reset", 3'd4, 32'h0000_0000, 0);

      // plain registers, masked cfg, read-only par
      bus_write(3'd0, 32'hffff_abcd);
      bus_read("cfg_masked", 3'd0, 32'h1234_abcd, 0);
      check("cfg_port", spi_cfg, 32'h1234_abcd);
      bus_write(3'd6, 32'hdead_beef);
      bus_write(3'd7, 32'h0bad_f00d);
      bus_read("rof_rw", 3'd6, 32'hdead_beef, 0);
      bus_read("wof_rw", 3'd7, 32'h0bad_f00d, 0);
      bus_write(3'd1, 32'hffff_ffff);
      bus_read("par_ro", 3'd1, 32'h0000_0722, 0);

      // fill command FIFO with one staged data word
      bus_write(3'd3, STG);
      for (int i = 0; i < 4; i++) begin
         cmo_exp_q.push_back({ctl_v[i], STG});
         bus_write(3'd2, wdt_v[i]);
      end
      bus_read("sts_cmo_full", 3'd2, 32'h0004_0006, 0);

      // fifth write stalls until one entry leaves
      cmo_exp_q.push_back({ctl_v[4], STG});
      reg_wen = 1'b1; reg_adr = 3'd2; reg_wdt = wdt_v[4];
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("wrq_cmo_full", reg_wrq, 1);
         step();
      end
      cmo_rdy = 1'b1;
      @(negedge clk);
      check("wrq_during_pop", reg_wrq, 1);
      step();
      cmo_rdy = 1'b0;
      @(negedge clk);
      check("wrq_released", reg_wrq, 0);
      step();
      reg_wen = 1'b0;
      bus_read("sts_cmo_refill", 3'd2, 32'h0004_0006, 0);

      // drain with irq 0 enabled
      bus_write(3'd4, 32'h0000_0100);
      bus_read("irq_ena0", 3'd4, 32'h0000_0100, 0);
      cmo_rdy = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (!cmo_vld) done = 1'b1;
      end
      check("cmo_drained", 64'(done), 1);
      check("irq_cmo_empty", reg_irq, 1);
      step();
      cmo_rdy = 1'b0;
      bus_read("irq_pend0", 3'd4, 32'h0000_0101, 0);
      bus_write(3'd4, 32'h0000_0001);
      @(negedge clk);
      check("irq_w1c", reg_irq, 0);
      step();

      // response FIFO fill, drain, underflow
      bus_write(3'd4, 32'h0000_0200);
      for (int i = 1; i <= 4; i++) cmi_send(4'(i + 8), 32'(i));
      @(negedge clk);
      check("cmi_rdy_full", cmi_rdy, 0);
      check("irq_cmi_push", reg_irq, 1);
      step();
      bus_read("sts_cmi_full", 3'd2, 32'h0400_0909, 0);
      for (int i = 1; i <= 4; i++) bus_read("cmi_data", 3'd3, 32'(i), 0);
      bus_read("cmi_underflow", 3'd3, 32'h0000_0000, 1);
      @(negedge clk);
      check("cmi_rdy_empty", cmi_rdy, 1);
      step();
      bus_read("irq_pend13", 3'd4, 32'h0000_020a, 0);

      // W1C coincident with a set event: set wins
      bus_write(3'd4, 32'h0000_020f);
      bus_read("irq_cleared", 3'd4, 32'h0000_0200, 0);
      cmi_vld = 1'b1; cmi_ctl = 4'h5; cmi_dat = 32'h55;
      reg_wen = 1'b1; reg_adr = 3'd4; reg_wdt = 32'h0000_0202;
      step();
      cmi_vld = 1'b0; reg_wen = 1'b0;
      bus_read("irq_set_wins", 3'd4, 32'h0000_0202, 0);
      bus_write(3'd4, 32'h0000_0002);
      bus_read("cmi_single", 3'd3, 32'h0000_0055, 0);
      bus_read("irq_idle", 3'd4, 32'h0000_0000, 0);

      // DMA task handshake
      reg_wen = 1'b1; reg_adr = 3'd5; reg_wdt = 32'h1357_9bdf;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("wrq_tsk", reg_wrq, 1);
         check("tsk_vld_held", tsk_vld, 0);
         step();
      end
      tsk_rdy = 1'b1;
      @(negedge clk);
      check("tsk_vld", tsk_vld, 1);
      check("tsk_ctl", tsk_ctl, 32'h1357_9bdf);
      step();
      reg_wen = 1'b0;
      @(negedge clk);
      check("tsk_vld_once", tsk_vld, 0);
      step();
      bus_read("tsk_sts", 3'd5, 32'hcafe_f00d, 0);
      bus_read("irq_pend2", 3'd4, 32'h0000_0004, 0);

      // reset mid-operation discards queued commands
      tsk_rdy = 1'b0;
      bus_write(3'd2, 32'h0000_0003);
      bus_write(3'd2, 32'h0000_0004);
      @(negedge clk);
      check("cmo_vld_pre_rst", cmo_vld, 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("cmo_vld_post_rst", cmo_vld, 0);
      check("cfg_post_rst", spi_cfg, CFG_RST);
      check("rof_post_rst", adr_rof, 32'h0000_1000);
      step();
      bus_read("sts_post_rst", 3'd2, 32'h0000_0005, 0);
      bus_read("irq_post_rst", 3'd4, 32'h0000_0000, 0);

      check("rd_queue_left", rd_exp_q.size(), 0);
      check("cmo_queue_left", cmo_exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
